// File: rtl/mux_2x1_rr_arbiter.sv
// Round-robin arbiter driving a shared 2:1 mux with a registered output stage.
// A burst counter limits how many consecutive words one requester may push.
module mux_2x1_rr_arbiter #(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_0_valid,
   input  logic [DATA_W-1:0] in_0_data,
   output logic              in_0_ready,
   input  logic              in_1_valid,
   input  logic [DATA_W-1:0] in_1_data,
   output logic              in_1_ready,
   output logic              mux_out_valid,
   output logic [DATA_W-1:0] mux_out_data,
   input  logic              mux_out_ready,
   output logic              sel
);

   localparam int CNT_W = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             last_grant;
   logic             last_nxt;
   logic             out_free;
   logic             acc_0;
   logic             acc_1;

   assign out_free   = !mux_out_valid || mux_out_ready;
   assign in_0_ready = (state == OWN0) && out_free;
   assign in_1_ready = (state == OWN1) && out_free;
   assign acc_0      = in_0_valid && in_0_ready;
   assign acc_1      = in_1_valid && in_1_ready;

   // A stalled owner (valid but no accept) falls through every branch and holds.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = burst_cnt;
      last_nxt  = last_grant;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (in_0_valid && in_1_valid) begin
               state_nxt = last_grant ? OWN0 : OWN1;
            end else if (in_0_valid) begin
               state_nxt = OWN0;
            end else if (in_1_valid) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (!in_0_valid) begin
               last_nxt  = 1'b0;
               cnt_nxt   = '0;
               state_nxt = in_1_valid ? OWN1 : IDLE;
            end else if (acc_0) begin
               if (burst_cnt == CNT_LAST) begin
                  cnt_nxt = '0;
                  if (in_1_valid) begin
                     state_nxt = OWN1;
                     last_nxt  = 1'b0;
                  end
               end else begin
                  cnt_nxt = burst_cnt + CNT_W'(1);
               end
            end
         end
         OWN1: begin
            if (!in_1_valid) begin
               last_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = in_0_valid ? OWN0 : IDLE;
            end else if (acc_1) begin
               if (burst_cnt == CNT_LAST) begin
                  cnt_nxt = '0;
                  if (in_0_valid) begin
                     state_nxt = OWN0;
                     last_nxt  = 1'b1;
                  end
               end else begin
                  cnt_nxt = burst_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // sel follows the owning requester and keeps its last value while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_grant <= 1'b1;
         sel        <= 1'b0;
      end else begin
         state      <= state_nxt;
         burst_cnt  <= cnt_nxt;
         last_grant <= last_nxt;
         if (state_nxt == OWN1) begin
            sel <= 1'b1;
         end else if (state_nxt == OWN0) begin
            sel <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_out_valid <= 1'b0;
         mux_out_data  <= '0;
      end else if (acc_0) begin
         mux_out_valid <= 1'b1;
         mux_out_data  <= in_0_data;
      end else if (acc_1) begin
         mux_out_valid <= 1'b1;
         mux_out_data  <= in_1_data;
      end else if (mux_out_ready) begin
         mux_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Directed bench for mux_2x1_rr_arbiter: reset, streaming, fairness,
// backpressure, early release and reset in the middle of a burst.
module tb_mux_2x1_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic       in_0_valid;
   logic [7:0] in_0_data;
   logic       in_0_ready;
   logic       in_1_valid;
   logic [7:0] in_1_data;
   logic       in_1_ready;
   logic       mux_out_valid;
   logic [7:0] mux_out_data;
   logic       mux_out_ready;
   logic       sel;

   int tests_run = 0;
   int tests_failed = 0;

   mux_2x1_rr_arbiter #(.DATA_W(8), .BURST_LEN(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_0_valid    (in_0_valid),
      .in_0_data     (in_0_data),
      .in_0_ready    (in_0_ready),
      .in_1_valid    (in_1_valid),
      .in_1_data     (in_1_data),
      .in_1_ready    (in_1_ready),
      .mux_out_valid (mux_out_valid),
      .mux_out_data  (mux_out_data),
      .mux_out_ready (mux_out_ready),
      .sel           (sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1,
                                input logic ordy);
      in_0_valid    = v0;
      in_0_data     = d0;
      in_1_valid    = v1;
      in_1_data     = d1;
      mux_out_ready = ordy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_valid"}, 32'(mux_out_valid), 32'd0);
      checkOutput({tag, "_data"},  32'(mux_out_data),  32'd0);
      checkOutput({tag, "_rdy0"},  32'(in_0_ready),    32'd0);
      checkOutput({tag, "_rdy1"},  32'(in_1_ready),    32'd0);
      checkOutput({tag, "_sel"},   32'(sel),           32'd0);
   endtask

   // Expected output order under continuous contention with BURST_LEN=4.
   function automatic logic [7:0] fairWord(input int g);
      int burst;
      logic [7:0] base;
      burst = g / 4;
      base  = ((burst % 2) != 0) ? 8'h10 : 8'h00;
      return base + 8'((burst / 2) * 4 + g % 4);
   endfunction

   initial begin
      int g, burst, owner;
      logic [7:0] d0, d1;

      rst_n = 1'b0;
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      nextCycle();
      nextCycle();
      checkReset("init_reset");
      rst_n = 1'b1;

      // Single stream
      nextCycle();
      applyStimulus(1, 8'hA1, 0, 8'h00, 1);
      checkOutput("s_idle_rdy0", 32'(in_0_ready), 32'd0);
      nextCycle();
      applyStimulus(1, 8'hA1, 0, 8'h00, 1);
      checkOutput("s_grant_rdy0", 32'(in_0_ready), 32'd1);
      checkOutput("s_grant_oval", 32'(mux_out_valid), 32'd0);
      nextCycle();
      applyStimulus(1, 8'hA2, 0, 8'h00, 1);
      checkOutput("s_w1_val", 32'(mux_out_valid), 32'd1);
      checkOutput("s_w1", 32'(mux_out_data), 32'hA1);
      nextCycle();
      applyStimulus(1, 8'hA3, 0, 8'h00, 1);
      checkOutput("s_w2", 32'(mux_out_data), 32'hA2);
      nextCycle();
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOutput("s_w3", 32'(mux_out_data), 32'hA3);
      checkOutput("s_w3_val", 32'(mux_out_valid), 32'd1);
      nextCycle();
      checkOutput("s_drain_val", 32'(mux_out_valid), 32'd0);
      checkOutput("s_sel", 32'(sel), 32'd0);

      // Mid-sim reset restores last_grant so in_0 wins the next contention
      nextCycle();
      rst_n = 1'b0;
      #1;
      checkReset("mid_reset");
      nextCycle();
      rst_n = 1'b1;

      // Fairness
      nextCycle();
      applyStimulus(1, 8'h00, 1, 8'h10, 1);
      checkOutput("f_idle_rdy0", 32'(in_0_ready), 32'd0);
      checkOutput("f_idle_rdy1", 32'(in_1_ready), 32'd0);
      for (int k = 1; k <= 16; k++) begin
         nextCycle();
         g     = k - 1;
         burst = g / 4;
         owner = burst % 2;
         if (owner == 0) begin
            d0 = fairWord(g);
            d1 = 8'h10 + 8'((burst / 2) * 4);
         end else begin
            d1 = fairWord(g);
            d0 = 8'(((burst + 1) / 2) * 4);
         end
         applyStimulus(1, d0, 1, d1, 1);
         checkOutput($sformatf("f_sel_%0d", k), 32'(sel), 32'(owner));
         checkOutput($sformatf("f_rdy0_%0d", k), 32'(in_0_ready), 32'(owner == 0));
         checkOutput($sformatf("f_rdy1_%0d", k), 32'(in_1_ready), 32'(owner == 1));
         if (k >= 2) begin
            checkOutput($sformatf("f_val_%0d", k), 32'(mux_out_valid), 32'd1);
            checkOutput($sformatf("f_data_%0d", k), 32'(mux_out_data), 32'(fairWord(k - 2)));
         end
      end
      nextCycle();
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOutput("f_last", 32'(mux_out_data), 32'h17);

      // Backpressure
      nextCycle();
      applyStimulus(1, 8'h55, 0, 8'h00, 1);
      checkOutput("b_idle_val", 32'(mux_out_valid), 32'd0);
      nextCycle();
      applyStimulus(1, 8'h55, 0, 8'h00, 1);
      checkOutput("b_grant_rdy0", 32'(in_0_ready), 32'd1);
      for (int k = 0; k < 5; k++) begin
         nextCycle();
         applyStimulus(1, 8'h66, 0, 8'h00, 0);
         checkOutput($sformatf("b_stall_data_%0d", k), 32'(mux_out_data), 32'h55);
         checkOutput($sformatf("b_stall_val_%0d", k), 32'(mux_out_valid), 32'd1);
         checkOutput($sformatf("b_stall_rdy0_%0d", k), 32'(in_0_ready), 32'd0);
      end
      nextCycle();
      applyStimulus(1, 8'h66, 0, 8'h00, 1);
      checkOutput("b_release_data", 32'(mux_out_data), 32'h55);
      checkOutput("b_release_rdy0", 32'(in_0_ready), 32'd1);
      nextCycle();
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOutput("b_next_data", 32'(mux_out_data), 32'h66);
      checkOutput("b_next_val", 32'(mux_out_valid), 32'd1);
      nextCycle();
      checkOutput("b_drain_val", 32'(mux_out_valid), 32'd0);

      // Early release; in_1 burst must run a full four words after the switch
      nextCycle();
      applyStimulus(1, 8'hC0, 0, 8'h00, 1);
      checkOutput("e_idle_rdy0", 32'(in_0_ready), 32'd0);
      nextCycle();
      applyStimulus(1, 8'hC0, 1, 8'hD0, 1);
      checkOutput("e_own0_rdy0", 32'(in_0_ready), 32'd1);
      checkOutput("e_own0_rdy1", 32'(in_1_ready), 32'd0);
      nextCycle();
      applyStimulus(1, 8'hC1, 1, 8'hD0, 1);
      checkOutput("e_c0", 32'(mux_out_data), 32'hC0);
      nextCycle();
      applyStimulus(0, 8'h00, 1, 8'hD0, 1);
      checkOutput("e_c1", 32'(mux_out_data), 32'hC1);
      checkOutput("e_c1_sel", 32'(sel), 32'd0);
      nextCycle();
      applyStimulus(0, 8'h00, 1, 8'hD0, 1);
      checkOutput("e_switch_sel", 32'(sel), 32'd1);
      checkOutput("e_switch_rdy1", 32'(in_1_ready), 32'd1);
      checkOutput("e_switch_val", 32'(mux_out_valid), 32'd0);
      nextCycle();
      applyStimulus(1, 8'hC2, 1, 8'hD1, 1);
      checkOutput("e_d0", 32'(mux_out_data), 32'hD0);
      nextCycle();
      applyStimulus(1, 8'hC2, 1, 8'hD2, 1);
      checkOutput("e_d1", 32'(mux_out_data), 32'hD1);
      checkOutput("e_d1_sel", 32'(sel), 32'd1);
      nextCycle();
      applyStimulus(1, 8'hC2, 1, 8'hD3, 1);
      checkOutput("e_d2", 32'(mux_out_data), 32'hD2);
      checkOutput("e_d2_sel", 32'(sel), 32'd1);
      nextCycle();
      applyStimulus(1, 8'hC2, 1, 8'hD4, 1);
      checkOutput("e_d3", 32'(mux_out_data), 32'hD3);
      checkOutput("e_back_sel", 32'(sel), 32'd0);
      checkOutput("e_back_rdy0", 32'(in_0_ready), 32'd1);
      nextCycle();
      applyStimulus(1, 8'hC3, 1, 8'hD4, 1);
      checkOutput("e_c2", 32'(mux_out_data), 32'hC2);

      // Reset in the middle of an in_1 burst
      nextCycle();
      applyStimulus(0, 8'h00, 1, 8'hD4, 1);
      checkOutput("r_c3", 32'(mux_out_data), 32'hC3);
      nextCycle();
      applyStimulus(0, 8'h00, 1, 8'hD4, 1);
      checkOutput("r_own1_sel", 32'(sel), 32'd1);
      nextCycle();
      applyStimulus(0, 8'h00, 1, 8'hD5, 1);
      checkOutput("r_d4", 32'(mux_out_data), 32'hD4);
      checkOutput("r_d4_val", 32'(mux_out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkReset("burst_reset");
      nextCycle();
      applyStimulus(1, 8'hE0, 1, 8'hD5, 1);
      checkReset("held_reset");
      rst_n = 1'b1;
      nextCycle();
      applyStimulus(1, 8'hE0, 1, 8'hD5, 1);
      checkOutput("r_grant_sel", 32'(sel), 32'd0);
      checkOutput("r_grant_rdy0", 32'(in_0_ready), 32'd1);
      checkOutput("r_grant_rdy1", 32'(in_1_ready), 32'd0);
      checkOutput("r_grant_val", 32'(mux_out_valid), 32'd0);
      nextCycle();
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOutput("r_e0", 32'(mux_out_data), 32'hE0);
      checkOutput("r_e0_val", 32'(mux_out_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
